// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Receive-side buffer for the UART RX path. Captures each frame
//            word from the deserializer, computes its parity error, and
//            stores {ferr, perr, data} in a show-ahead FIFO that is drained
//            through a valid/ready read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WORD_WIDTH:0]        rx_word,
    input  logic                       rx_done,
    input  logic                       rx_frame_err,
    input  logic                       parity_en,
    input  logic                       parity_odd,
    input  logic                       flush,
    input  logic                       clr_overflow,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WORD_WIDTH-1:0]      rd_data,
    output logic                       rd_perr,
    output logic                       rd_ferr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = WORD_WIDTH + 2;

    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);

    // Storage is deliberately left unreset; only the pointers define validity.
    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;

    logic                  w_wr_evt;
    logic [WORD_WIDTH-1:0] w_data;
    logic                  w_pbit;
    logic                  w_perr;
    logic [ENTRY_W-1:0]    w_entry;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf_set;
    logic [ENTRY_W-1:0]    w_head;

    // Frame decode: extract data/parity according to the current parity setting.
    always_comb begin
        w_wr_evt = rx_done | rx_frame_err;
        w_pbit   = rx_word[WORD_WIDTH];
        w_data   = rx_word[WORD_WIDTH-1:0];
        w_perr   = 1'b0;
        if (parity_en) begin
            w_perr = ((^w_data) ^ w_pbit) != parity_odd;
        end else begin
            w_data = rx_word[WORD_WIDTH:1];
        end
        // A collision of both pulses is treated as a framing error.
        w_entry  = {rx_frame_err, w_perr, w_data};
    end

    // Push/pop qualification; a full FIFO still accepts a write when it pops.
    always_comb begin
        w_full    = (r_count == c_depth_cnt);
        w_pop     = (r_count != '0) & rd_ready & ~flush;
        w_push    = w_wr_evt & (~w_full | w_pop) & ~flush;
        w_ovf_set = w_wr_evt & w_full & ~w_pop & ~flush;
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // Show-ahead read port: head entry is presented combinationally.
    always_comb begin
        w_head   = r_mem[r_rd_ptr];
        rd_valid = (r_count != '0);
        rd_data  = w_head[WORD_WIDTH-1:0];
        rd_perr  = w_head[WORD_WIDTH];
        rd_ferr  = w_head[WORD_WIDTH+1];
        count    = r_count;
        full     = w_full;
        overflow = r_overflow;
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo: table of single-frame
//            decode vectors followed by directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic [8:0] rx_word;
    logic       rx_done;
    logic       rx_frame_err;
    logic       parity_en;
    logic       parity_odd;
    logic       flush;
    logic       clr_overflow;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_ferr;
    logic [4:0] count;
    logic       full;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.WORD_WIDTH(8), .DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_word      (rx_word),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_perr      (rd_perr),
        .rd_ferr      (rd_ferr),
        .count        (count),
        .full         (full),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] word;
        logic       pe;
        logic       po;
        logic       fe;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] w, input logic pe, input logic po, input logic fe);
        rx_word      = w;
        parity_en    = pe;
        parity_odd   = po;
        rx_done      = ~fe;
        rx_frame_err = fe;
        tick();
        rx_done      = 1'b0;
        rx_frame_err = 1'b0;
    endtask

    task automatic pop();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    // Fill the FIFO with data 0..15 using unparitied frames.
    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            push({i[7:0], 1'b0}, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{9'h0AB, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{9'h103, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[2] = '{9'h103, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[3] = '{9'h041, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1};
        vecs[4] = '{9'h1FF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{9'h0FF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{9'h0FF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{9'h155, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1};
        vecs[8] = '{9'h080, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 1'b1};

        rst_n = 1'b0; rx_word = '0; rx_done = 1'b0; rx_frame_err = 1'b0;
        parity_en = 1'b0; parity_odd = 1'b0; flush = 1'b0;
        clr_overflow = 1'b0; rd_ready = 1'b0;
        #12;
        chk("reset rd_valid", rd_valid, 0);
        chk("reset count", count, 0);
        chk("reset full", full, 0);
        chk("reset overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        // Single-frame decode table.
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].word, vecs[i].pe, vecs[i].po, vecs[i].fe);
            chk($sformatf("vec%0d rd_valid", i), rd_valid, 1);
            chk($sformatf("vec%0d count", i), count, 1);
            chk($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_data);
            chk($sformatf("vec%0d rd_perr", i), rd_perr, vecs[i].exp_perr);
            chk($sformatf("vec%0d rd_ferr", i), rd_ferr, vecs[i].exp_ferr);
            pop();
            chk($sformatf("vec%0d popped rd_valid", i), rd_valid, 0);
            chk($sformatf("vec%0d popped count", i), count, 0);
        end

        // Stored entry keeps the parity setting it was written with.
        push(9'h103, 1'b1, 1'b0, 1'b0);
        parity_odd = 1'b1;
        parity_en  = 1'b0;
        tick();
        chk("sampled cfg perr", rd_perr, 1);
        chk("sampled cfg data", rd_data, 8'h03);
        pop();

        // Fill to full (pointers start mid-array, so this wraps), then overflow.
        fill16();
        chk("fill count", count, 16);
        chk("fill full", full, 1);
        chk("fill overflow", overflow, 0);
        push(9'h1DC, 1'b0, 1'b0, 1'b0);
        chk("drop overflow", overflow, 1);
        chk("drop count", count, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain1 data%0d", i), rd_data, i);
            pop();
        end
        chk("drain1 rd_valid", rd_valid, 0);
        chk("drain1 count", count, 0);
        chk("drain1 overflow sticky", overflow, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr overflow", overflow, 0);

        // Full with simultaneous push and pop.
        fill16();
        chk("fill2 head", rd_data, 0);
        rd_ready = 1'b1;
        push(9'h0EE, 1'b0, 1'b0, 1'b0);
        rd_ready = 1'b0;
        chk("pushpop count", count, 16);
        chk("pushpop full", full, 1);
        chk("pushpop overflow", overflow, 0);
        chk("pushpop new head", rd_data, 1);
        // Drop while clearing: set wins.
        clr_overflow = 1'b1;
        push(9'h132, 1'b0, 1'b0, 1'b0);
        clr_overflow = 1'b0;
        chk("set beats clr", overflow, 1);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain2 data%0d", i), rd_data, i);
            pop();
        end
        chk("drain2 last data", rd_data, 8'h77);
        chk("drain2 last count", count, 1);
        pop();
        chk("drain2 empty", rd_valid, 0);

        // Empty FIFO: write with rd_ready high does not pop.
        rd_ready = 1'b1;
        push(9'h024, 1'b0, 1'b0, 1'b0);
        rd_ready = 1'b0;
        chk("empty push count", count, 1);
        chk("empty push valid", rd_valid, 1);
        chk("empty push data", rd_data, 8'h12);
        pop();

        // Flush with 5 stored entries and a concurrent write.
        for (int i = 0; i < 5; i++) begin
            push({i[7:0], 1'b1}, 1'b0, 1'b0, 1'b0);
        end
        chk("pre flush count", count, 5);
        flush = 1'b1;
        push(9'h0AA, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        chk("flush count", count, 0);
        chk("flush rd_valid", rd_valid, 0);
        chk("flush overflow", overflow, 1);
        tick();
        chk("flush write discarded", count, 0);

        // Asynchronous reset mid-fill.
        for (int i = 0; i < 3; i++) begin
            push({i[7:0], 1'b0}, 1'b0, 1'b0, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst count", count, 0);
        chk("async rst rd_valid", rd_valid, 0);
        chk("async rst full", full, 0);
        chk("async rst overflow", overflow, 0);
        rst_n = 1'b1;
        tick();
        chk("post rst count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
